// File: rtl/cmp_sweep_checker.sv
// Comparator self-test sequencer: sweeps every (A,B) pair through an external comparator
// and checks its flags. Define CMP_STOP_ON_ERR_EN to end the sweep at the first mismatch.
module cmp_sweep_checker #(
    parameter int W      = 2,
    parameter int SETTLE = 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    output logic [W-1:0]   a_out,
    output logic [W-1:0]   b_out,
    input  logic           gt_in,
    input  logic           eq_in,
    input  logic           lt_in,
    output logic           busy,
    output logic           done,
    output logic           pass,
    output logic [2*W:0]   err_count,
    output logic [W-1:0]   first_err_a,
    output logic [W-1:0]   first_err_b
);

    localparam int             CW   = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [W-1:0]   MAXV = '1;

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_CHECK, ST_DONE} state_t;

    state_t        r_state;
    state_t        w_next;
    logic [CW-1:0] r_cnt;
    logic [2:0]    w_exp;
    logic          w_mismatch;
    logic          w_last;
    logic          w_settled;
    logic          w_stop;

    // NOTE: sequential state uses <= so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next;
    end

    // Decode of the pair under test; any flag difference counts, so non-one-hot flags fail.
    always_comb begin
        w_exp      = {a_out > b_out, a_out == b_out, a_out < b_out};
        w_mismatch = ({gt_in, eq_in, lt_in} != w_exp);
        w_last     = (a_out == MAXV) && (b_out == MAXV);
        w_settled  = (r_cnt == CW'(SETTLE - 1));
`ifdef CMP_STOP_ON_ERR_EN
        w_stop     = w_mismatch;
`else
        w_stop     = 1'b0;
`endif
    end

    // NOTE: default assignment first keeps this combinational block latch-free.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (start)     w_next = ST_WAIT;
            ST_WAIT:  if (w_settled) w_next = ST_CHECK;
            ST_CHECK: w_next = (w_last || w_stop) ? ST_DONE : ST_WAIT;
            ST_DONE:  w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_out       <= '0;
            b_out       <= '0;
            r_cnt       <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            pass        <= 1'b0;
            err_count   <= '0;
            first_err_a <= '0;
            first_err_b <= '0;
        end else begin
            done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        a_out       <= '0;
                        b_out       <= '0;
                        r_cnt       <= '0;
                        err_count   <= '0;
                        pass        <= 1'b0;
                        first_err_a <= '0;
                        first_err_b <= '0;
                        busy        <= 1'b1;
                    end
                end
                ST_WAIT: r_cnt <= r_cnt + CW'(1);
                ST_CHECK: begin
                    if (w_mismatch) begin
                        err_count <= err_count + (2*W+1)'(1);
                        if (err_count == '0) begin
                            first_err_a <= a_out;
                            first_err_b <= b_out;
                        end
                    end
                    // Operands freeze on the final (or failing) pair so they can be inspected.
                    if (w_next == ST_DONE) begin
                        busy <= 1'b0;
                        done <= 1'b1;
                        pass <= !w_mismatch && (err_count == '0);
                    end else begin
                        r_cnt <= '0;
                        b_out <= b_out + W'(1);
                        if (b_out == MAXV) a_out <= a_out + W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
